// File: rtl/booth_sched_pkg.sv
// Shared types and the round-robin grant helper for booth_mult_sched.
// Optional build macro: EARLY_TERM_EN (consumed by booth_mult_sched).
package booth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper bound on requesters supported by rr_pick; callers use the low bits.
    localparam int MAX_REQ = 32;

    // One-hot grant: first valid bit found searching upward from ptr, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int ptr,
                                                   input int nreq);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < nreq && !found) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (valid[idx[4:0]]) begin
                    grant[idx[4:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/booth_mult_sched_if.sv
// Request/response bundle between the requesters, the consumer and the shared Booth multiplier.
// master = requester/consumer side, slave = multiplier side.
interface booth_mult_sched_if #(
    parameter int W    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of mcand into the upper half, then >>>1.
module booth_step #(
    parameter int W = 64
) (
    input  logic [2*W:0]  p,
    input  logic [W-1:0]  mcand,
    output logic [2*W:0]  p_next
);
    logic [W:0] hi;
    logic [W:0] m_ext;
    logic [W:0] sum;

    // The add is one bit wider than the upper half so the bit shifted in is the true sign;
    // this keeps -2^(W-1) * -2^(W-1) exact.
    always_comb begin
        hi    = {p[2*W], p[2*W:W+1]};
        m_ext = {mcand[W-1], mcand};
        case (p[1:0])
            2'b01:   sum = hi + m_ext;
            2'b10:   sum = hi - m_ext;
            default: sum = hi;
        endcase
        p_next = {sum, p[W:1]};
    end
endmodule

// File: rtl/booth_mult_sched.sv
// Round-robin shared sequential Booth multiplier; returns tagged signed products.
// Build macro EARLY_TERM_EN: stop as soon as the remaining multiplier bits cannot cause an add.
module booth_mult_sched
    import booth_sched_pkg::*;
#(
    parameter int W    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               Clk,
    input  logic               Reset,
    booth_mult_sched_if.slave  bus
);
    localparam int PW = 2 * W + 1;
    localparam int SW = $clog2(W + 1);

    state_t           state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [W-1:0]     mcand_reg;
    logic [PW-1:0]    p_reg;
    logic [SW-1:0]    step_reg;
    logic             rsp_valid_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [2*W-1:0]   rsp_p_reg;

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] pick;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     winner;
    logic [W-1:0]       a_vec [NREQ];
    logic [W-1:0]       b_vec [NREQ];
    logic [PW-1:0]      p_step;
    logic [2*W-1:0]     p_result;
    logic               term;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_vec[gi] = bus.req_a[gi*W +: W];
            assign b_vec[gi] = bus.req_b[gi*W +: W];
        end
    endgenerate

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = bus.req_valid;
        pick                  = rr_pick(valid_ext, int'(rr_ptr_reg), NREQ);
        grant                 = (state_reg == IDLE && Reset) ? pick[NREQ-1:0] : '0;
        winner                = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                winner = IDW'(i);
            end
        end
    end

    booth_step #(.W(W)) u_step (
        .p      (p_reg),
        .mcand  (mcand_reg),
        .p_next (p_step)
    );

`ifdef EARLY_TERM_EN
    logic [PW-1:0] tail_mask;
    logic [PW-1:0] p_shift;

    // tail_mask covers P[W-step:0]; uniform tail means only pure shifts remain.
    always_comb begin
        tail_mask = {PW{1'b1}} >> (W + int'(step_reg));
        p_shift   = $signed(p_reg) >>> (W - int'(step_reg));
        term      = ((p_reg & tail_mask) == '0) || ((p_reg & tail_mask) == tail_mask);
        p_result  = p_shift[PW-1:1];
    end
`else
    always_comb begin
        term     = (step_reg == SW'(W));
        p_result = p_reg[PW-1:1];
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            mcand_reg     <= '0;
            p_reg         <= '0;
            step_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_p_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        mcand_reg  <= a_vec[winner];
                        p_reg      <= {{W{1'b0}}, b_vec[winner], 1'b0};
                        step_reg   <= '0;
                        id_reg     <= winner;
                        rr_ptr_reg <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (term) begin
                        rsp_p_reg     <= p_result;
                        rsp_id_reg    <= id_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        p_reg    <= p_step;
                        step_reg <= step_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_p     = rsp_p_reg;
endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed and table-driven checks of booth_mult_sched with W=8, NREQ=4.
module tb_booth_mult_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    booth_mult_sched_if #(.W(8), .NREQ(4)) bus ();

    booth_mult_sched #(.W(8), .NREQ(4)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          id;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (bus.rsp_valid !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (cycles >= 40) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    // Issues one request, measures edges from accept to rsp_valid, then completes the handshake.
    task automatic run_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] p, output int rid, output int lat);
        int guard;
        p   = '0;
        rid = -1;
        lat = 0;
        @(negedge clk);
        bus.req_a[id*8 +: 8] = a;
        bus.req_b[id*8 +: 8] = b;
        bus.req_valid[id]    = 1'b1;
        #1;
        guard = 0;
        while (bus.req_ready[id] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 40) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        wait_rsp(lat);
        p   = bus.rsp_p;
        rid = int'(bus.rsp_id);
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  rr_a   [4];
    logic [7:0]  rr_b   [4];
    logic [15:0] rr_exp [4];

    initial begin
        logic [15:0] p;
        int          rid;
        int          lat;
        int          cyc;
        int          seen;
        logic signed [15:0] ea;
        logic signed [15:0] eb;
        logic [15:0] ep;
        int          rid_req;
        logic [7:0]  ra;
        logic [7:0]  rb;

        checks = 0;
        errors = 0;
        vecs[0] = '{8'd3,   8'hFB, 0, 16'hFFF1};
        vecs[1] = '{8'h80,  8'h80, 1, 16'h4000};
        vecs[2] = '{8'h7F,  8'h80, 2, 16'hC080};
        vecs[3] = '{8'hFF,  8'hFF, 3, 16'h0001};
        vecs[4] = '{8'd0,   8'd77, 0, 16'h0000};
        vecs[5] = '{8'hF9,  8'd9,  1, 16'hFFC1};
        vecs[6] = '{8'd100, 8'd100, 2, 16'h2710};
        vecs[7] = '{8'h80,  8'h7F, 3, 16'hC080};
        vecs[8] = '{8'h7F,  8'h7F, 0, 16'h3F01};
        vecs[9] = '{8'h80,  8'd1,  1, 16'hFF80};

        rr_a = '{8'd3, 8'hFC, 8'd5, 8'hFA};
        rr_b = '{8'd7, 8'd7, 8'hF7, 8'hF7};
        rr_exp = '{16'h0015, 16'hFFE4, 16'hFFD3, 16'h0036};

        rst_n          = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 4'hF;
        bus.req_a      = {rr_a[3], rr_a[2], rr_a[1], rr_a[0]};
        bus.req_b      = {rr_b[3], rr_b[2], rr_b[1], rr_b[0]};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_p",     32'(bus.rsp_p),     32'd0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);

        // All requesters valid from reset: strict rotation 0,1,2,3,0
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr_first_grant", 32'(bus.req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            wait_rsp(cyc);
            chk("rr_id", 32'(bus.rsp_id), 32'(k % 4));
            chk("rr_p",  32'(bus.rsp_p),  32'(rr_exp[k % 4]));
            $display("TXN rr k=%0d id=%0d p=%04h", k, bus.rsp_id, bus.rsp_p);
            if (k == 4) bus.req_valid = '0;
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].id, vecs[i].a, vecs[i].b, p, rid, lat);
            chk("vec_p",  32'(p),   32'(vecs[i].p));
            chk("vec_id", 32'(rid), 32'(vecs[i].id));
`ifdef EARLY_TERM_EN
            chk("vec_lat_bound", 32'(lat <= 9), 32'd1);
`else
            chk("vec_lat", 32'(lat), 32'd9);
`endif
            chk("vec_rsp_drop", 32'(bus.rsp_valid), 32'd0);
            $display("TXN vec i=%0d id=%0d a=%02h b=%02h p=%04h lat=%0d", i, rid, vecs[i].a, vecs[i].b, p, lat);
        end

        // Back-pressure: product held while rsp_ready is low, no new grant
        @(negedge clk);
        bus.rsp_ready    = 1'b0;
        bus.req_a[23:16] = 8'hFD;
        bus.req_b[23:16] = 8'd7;
        bus.req_valid[2] = 1'b1;
        #1;
        cyc = 0;
        while (bus.req_ready[2] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        wait_rsp(cyc);
        @(negedge clk);
        bus.req_a[15:8]  = 8'd2;
        bus.req_b[15:8]  = 8'd2;
        bus.req_valid[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_p",     32'(bus.rsp_p),     32'hFFEB);
            chk("hold_id",    32'(bus.rsp_id),    32'd2);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        $display("TXN hold id=%0d p=%04h", bus.rsp_id, bus.rsp_p);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("release_idle_grant", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;

        // Reset in the middle of an operation
        @(negedge clk);
        bus.req_a[15:8]  = 8'd11;
        bus.req_b[15:8]  = 8'd13;
        bus.req_valid[1] = 1'b1;
        #1;
        chk("abort_req_grant", 32'(bus.req_ready), 32'h2);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_rsp_p",     32'(bus.rsp_p),     32'd0);
        chk("abort_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid === 1'b1) seen = 1;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        @(negedge clk);
        bus.req_a[7:0]   = 8'd6;
        bus.req_b[7:0]   = 8'hFE;
        bus.req_a[31:24] = 8'd9;
        bus.req_b[31:24] = 8'd9;
        bus.req_valid    = 4'b1001;
        #1;
        chk("ptr_after_reset", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        wait_rsp(cyc);
        chk("post_reset_id", 32'(bus.rsp_id), 32'd0);
        chk("post_reset_p",  32'(bus.rsp_p),  32'hFFF4);
        $display("TXN post_reset id=%0d p=%04h", bus.rsp_id, bus.rsp_p);
        @(posedge clk);
        #1;

`ifdef EARLY_TERM_EN
        run_req(0, 8'd5, 8'd0, p, rid, lat);
        chk("early_zero_p",   32'(p), 32'd0);
        chk("early_zero_lat", 32'(lat <= 2), 32'd1);
        $display("TXN early a=5 b=0 p=%04h lat=%0d", p, lat);
        run_req(2, 8'hDB, 8'hFF, p, rid, lat);
        chk("early_neg1_p",   32'(p), 32'h0025);
        chk("early_neg1_lat", 32'(lat <= 2), 32'd1);
        $display("TXN early a=-37 b=-1 p=%04h lat=%0d", p, lat);
`endif

        for (int r = 0; r < 300; r++) begin
            rid_req = int'($urandom_range(0, 3));
            ra      = 8'($urandom);
            rb      = 8'($urandom);
            ea      = 16'($signed(ra));
            eb      = 16'($signed(rb));
            ep      = 16'(ea * eb);
            run_req(rid_req, ra, rb, p, rid, lat);
            chk("rand_p",  32'(p),   32'(ep));
            chk("rand_id", 32'(rid), 32'(rid_req));
            $display("TXN rand r=%0d id=%0d a=%02h b=%02h p=%04h lat=%0d", r, rid, ra, rb, p, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
